// File: rtl/mips_pkg.sv
// Shared MIPS ID-stage definitions: opcodes, ALUOp codes, ID/EX bus layout and decode helpers.
package mips_pkg;

  localparam int ID_BUS_W = 152;
  localparam int CTRL_W   = 9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // ID_out field offsets (LSB position) and widths
  localparam int OFF_RD    = 0;
  localparam int OFF_RT    = 5;
  localparam int OFF_RS    = 10;
  localparam int OFF_IMM   = 15;
  localparam int OFF_RTD   = 47;
  localparam int OFF_RSD   = 79;
  localparam int OFF_PC4   = 111;
  localparam int OFF_CTRL  = 143;
  localparam int W_REGIDX  = 5;
  localparam int W_WORD    = 32;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_bus_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.alu_op = ALUOP_FUNCT; c.reg_write = 1'b1; end
      OP_LW:    begin c.alu_src = 1'b1; c.alu_op = ALUOP_ADD; c.mem_read = 1'b1;
                      c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      OP_SW:    begin c.alu_src = 1'b1; c.alu_op = ALUOP_ADD; c.mem_write = 1'b1; end
      OP_BEQ:   begin c.alu_op = ALUOP_SUB; c.branch = 1'b1; end
      OP_ADDI:  begin c.alu_src = 1'b1; c.alu_op = ALUOP_ADD; c.reg_write = 1'b1; end
      OP_ANDI, OP_ORI, OP_LUI:
                begin c.alu_src = 1'b1; c.alu_op = ALUOP_IMM; c.reg_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm16);
    case (op)
      OP_ANDI, OP_ORI: return {16'h0, imm16};
      OP_LUI:          return {imm16, 16'h0};
      default:         return {{16{imm16[15]}}, imm16};
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one sync write port, debug read port.
// Build with ID_WB_BYPASS_EN to forward a same-cycle write onto the rs/rt read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_en,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  input  logic [AW-1:0]     i_raddr_b,
  input  logic [AW-1:0]     i_dbg_addr,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              w_wr_nz;
  logic [DATA_W-1:0] w_arr_a;
  logic [DATA_W-1:0] w_arr_b;

  assign w_wr_nz = i_we && (i_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_nz && i_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // R0 is hardwired; never trust the array slot for it
  assign w_arr_a    = (i_raddr_a  == '0) ? '0 : r_regs[i_raddr_a];
  assign w_arr_b    = (i_raddr_b  == '0) ? '0 : r_regs[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

`ifdef ID_WB_BYPASS_EN
  assign o_rdata_a = (w_wr_nz && i_waddr == i_raddr_a) ? i_wdata : w_arr_a;
  assign o_rdata_b = (w_wr_nz && i_waddr == i_raddr_b) ? i_wdata : w_arr_b;
`else
  assign o_rdata_a = w_arr_a;
  assign o_rdata_b = w_arr_b;
`endif

endmodule

// File: rtl/inst_decode.sv
// MIPS ID stage: register file, control decode, immediate extend, load-use hazard, ID/EX latch.
// Optional ID_WB_BYPASS_EN forwards a same-cycle WB write to the rs/rt read data.
module inst_decode
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                DB_WE,
  input  logic [63:0]         IF_in,
  input  logic                flush,
  input  logic                ex_mem_read,
  input  logic [4:0]          ex_rt,
  input  logic                wb_reg_write,
  input  logic [4:0]          wb_write_reg,
  input  logic [DATA_W-1:0]   wb_write_data,
  input  logic [4:0]          dbg_reg_addr,
  output logic                PC_Write,
  output logic                IFID_Write,
  output logic [ID_BUS_W-1:0] ID_out,
  output logic [DATA_W-1:0]   dbg_reg_data
);

  logic [31:0]       w_instr;
  logic [5:0]        w_op;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic              w_stall;
  id_bus_t           w_next;
  id_bus_t           r_id;

  assign w_instr = IF_in[31:0];
  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];

  reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk        (clk),
    .rst        (reset),
    .i_we       (wb_reg_write),
    .i_en       (DB_WE),
    .i_waddr    (wb_write_reg),
    .i_wdata    (wb_write_data),
    .i_raddr_a  (w_rs),
    .i_raddr_b  (w_rt),
    .i_dbg_addr (dbg_reg_addr),
    .o_rdata_a  (w_rs_data),
    .o_rdata_b  (w_rt_data),
    .o_dbg_data (dbg_reg_data)
  );

  // Conservative: both source fields are checked whatever the opcode
  assign w_stall = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == w_rs) || (ex_rt == w_rt));

  // A taken branch overrides the stall so the target fetch proceeds
  assign PC_Write   = ~w_stall | flush;
  assign IFID_Write = ~w_stall | flush;

  always_comb begin
    w_next         = '0;
    w_next.ctrl    = decode_ctrl(w_op);
    w_next.pc4     = IF_in[63:32];
    w_next.rs_data = w_rs_data;
    w_next.rt_data = w_rt_data;
    w_next.imm     = ext_imm(w_op, w_instr[15:0]);
    w_next.rs      = w_rs;
    w_next.rt      = w_rt;
    w_next.rd      = w_rd;
    if (flush || w_stall) w_next.ctrl = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_id <= '0;
    else if (DB_WE) r_id <= w_next;
  end

  assign ID_out = r_id;

endmodule
